// File: rtl/vga_line_fetch.sv
// vga_line_fetch: memory-backed pixel source for the 640x480 64-colour VGA
// output stage. Each visible line is prefetched from a word-addressed frame
// memory into one bank of a ping-pong line buffer, one line ahead of the
// display. Line L always lives in bank L[0].
//
// Ports:
//   clk12        pixel clock, all logic on the rising edge
//   reset        synchronous active-high reset (shared with the memory)
//   frame_start  one-cycle pulse before visible line 0; fetches line 0
//   de           visible-area enable; its rising edge on line y fetches y+1
//   vis_x/vis_y  visible coordinates, valid while de=1
//   pix_color    RRGGBB, one cycle after the coordinates
//   mem_req/mem_addr/mem_ack/mem_data  frame memory read port
//   fetch_busy   fetch FSM is not IDLE (exposes the FSM state)
//   underrun     sticky: a displayed pixel came from a non-resident line
//   overrun      sticky: a line trigger was dropped because a fetch was busy
//
// Memory handshake: mem_req is held high with mem_addr stable until the
// cycle mem_ack is high; that cycle completes the transfer and mem_data is
// valid only then. After an ack the next address (if any) appears on the
// following cycle with mem_req still high.
module vga_line_fetch #(
  parameter int                H_WORDS        = 160,
  parameter int                V_LINES        = 480,
  parameter int                ADDR_W         = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [5:0]        UNDERRUN_COLOR = 6'h30
) (
  input  logic              clk12,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              de,
  input  logic [9:0]        vis_x,
  input  logic [8:0]        vis_y,
  output logic [5:0]        pix_color,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [23:0]       mem_data,
  output logic              fetch_busy,
  output logic              underrun,
  output logic              overrun
);

  localparam int                WW          = $clog2(H_WORDS);
  localparam logic [WW-1:0]     LAST_WORD   = WW'(H_WORDS - 1);
  localparam logic [8:0]        LAST_LINE   = 9'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state;
  logic [WW-1:0] word_cnt;
  logic [8:0]    cur_line;
  logic [1:0]    bank_valid;
  logic [8:0]    bank_tag [2];
  logic [23:0]   lbuf [2][H_WORDS];
  logic          de_q;

  logic          de_trig;
  logic          start_fetch;
  logic [8:0]    start_line;
  logic          buf_we;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [8:0] l);
    return BASE_ADDR + ADDR_W'(l) * LINE_STRIDE;
  endfunction

  // The last visible line has no successor, so its de edge triggers nothing.
  assign de_trig    = de && !de_q && (vis_y < LAST_LINE);
  assign fetch_busy = (state != IDLE);

  // A new fetch starts from IDLE on any trigger, or toward line 0 once the
  // transfer outstanding at a frame_start abort has been acked. frame_start
  // always takes priority over a de trigger in the same cycle.
  always_comb begin
    start_fetch = 1'b0;
    start_line  = '0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_fetch = 1'b1;
        end else if (de_trig) begin
          start_fetch = 1'b1;
          start_line  = vis_y + 9'd1;
        end
      end
      REQ:     start_fetch = frame_start && mem_ack;
      DRAIN:   start_fetch = mem_ack;
      default: start_fetch = 1'b0;
    endcase
  end

  // Data acked during an abort belongs to the abandoned line and is dropped.
  assign buf_we = (state == REQ) && mem_ack && !frame_start;

  always_ff @(posedge clk12) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      word_cnt    <= '0;
      cur_line    <= '0;
      bank_valid  <= '0;
      bank_tag[0] <= '0;
      bank_tag[1] <= '0;
      overrun     <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      de_q <= de;
      if (de_trig && !frame_start && state != IDLE) begin
        overrun <= 1'b1;
      end
      if (start_fetch) begin
        state                    <= REQ;
        cur_line                 <= start_line;
        word_cnt                 <= '0;
        mem_req                  <= 1'b1;
        mem_addr                 <= line_addr(start_line);
        bank_valid[start_line[0]] <= 1'b0;
        bank_tag[start_line[0]]   <= start_line;
      end else begin
        case (state)
          REQ: begin
            if (frame_start) begin
              // Request already presented; keep it up until its ack arrives.
              state <= DRAIN;
            end else if (mem_ack) begin
              if (word_cnt == LAST_WORD) begin
                bank_valid[cur_line[0]] <= 1'b1;
                state                   <= IDLE;
                mem_req                 <= 1'b0;
              end else begin
                word_cnt <= word_cnt + WW'(1);
                mem_addr <= mem_addr + ADDR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Line buffer storage: no reset, contents are qualified by bank_valid.
  always_ff @(posedge clk12) begin
    if (buf_we) begin
      lbuf[cur_line[0]][word_cnt] <= mem_data;
    end
  end

  logic [23:0] rd_word;
  logic        rd_hit;
  logic [5:0]  rd_pix;

  assign rd_word = lbuf[vis_y[0]][vis_x[9:2]];
  assign rd_hit  = bank_valid[vis_y[0]] && (bank_tag[vis_y[0]] == vis_y);

  always_comb begin
    rd_pix = rd_word[5:0];
    case (vis_x[1:0])
      2'd0: rd_pix = rd_word[5:0];
      2'd1: rd_pix = rd_word[11:6];
      2'd2: rd_pix = rd_word[17:12];
      2'd3: rd_pix = rd_word[23:18];
      default: rd_pix = rd_word[5:0];
    endcase
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      pix_color <= '0;
      underrun  <= 1'b0;
    end else if (!de) begin
      pix_color <= '0;
    end else if (rd_hit) begin
      pix_color <= rd_pix;
    end else begin
      pix_color <= UNDERRUN_COLOR;
      underrun  <= 1'b1;
    end
  end

endmodule
